// File: rtl/div_arbiter.sv
// Round-robin front end that shares one pipelined divider among NUM_REQ requesters.
// A tag FIFO remembers who issued each in-flight op so in-order results go back to their owner.
module div_arbiter #(
   parameter int EXP_WIDTH  = 8,
   parameter int MANT_WIDTH = 7,
   parameter int NUM_REQ    = 4,
   parameter int MAX_OUT    = 4,
   localparam int WIDTH     = EXP_WIDTH + MANT_WIDTH,
   localparam int W         = WIDTH + 1,
   localparam int IDW       = $clog2(NUM_REQ),
   localparam int PW        = $clog2(MAX_OUT),
   localparam int CW        = PW + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [NUM_REQ*W-1:0] req_op1,
   input  logic [NUM_REQ*W-1:0] req_op2,
   output logic [NUM_REQ-1:0]   resp_valid,
   input  logic [NUM_REQ-1:0]   resp_ready,
   output logic [W-1:0]         resp_result,
   output logic                 div_valid_in,
   input  logic                 div_ready_in,
   output logic [W-1:0]         div_op1,
   output logic [W-1:0]         div_op2,
   input  logic                 div_valid_out,
   output logic                 div_ready_out,
   input  logic [W-1:0]         div_result,
   input  logic                 flush,
   output logic                 flush_done,
   output logic                 busy,
   output logic                 err_orphan
);

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

   state_t           state_q;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic             lock_q, lock_d;
   logic [IDW-1:0]   lock_id_q, lock_id_d;
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_orphan_q;
   logic [IDW-1:0]   tag_q [MAX_OUT];

   logic [W-1:0]     op1_arr [NUM_REQ];
   logic [W-1:0]     op2_arr [NUM_REQ];
   logic             scan_found;
   logic [IDW-1:0]   scan_id;
   logic [IDW-1:0]   grant_id;
   logic             grant_req;
   logic             issue_en;
   logic             issue_fire;
   logic             fifo_nonempty;
   logic [IDW-1:0]   head_id;
   logic             pop_fire;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign op1_arr[gi] = req_op1[gi*W +: W];
      assign op2_arr[gi] = req_op2[gi*W +: W];
   end

   function automatic logic [IDW-1:0] rot_idx(input logic [IDW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return IDW'(s);
   endfunction

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      logic [IDW-1:0] idx;
      scan_found = 1'b0;
      scan_id    = '0;
      idx        = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = rot_idx(rr_ptr_q, k);
         if (!scan_found && req_valid[idx]) begin
            scan_found = 1'b1;
            scan_id    = idx;
         end
      end
   end

   // A stalled offer keeps its grant so the divider sees stable operands.
   assign grant_id   = lock_q ? lock_id_q : scan_id;
   assign grant_req  = lock_q ? req_valid[lock_id_q] : scan_found;
   assign issue_en   = (state_q == ST_RUN) && (cnt_q != CW'(MAX_OUT));

   assign div_valid_in = issue_en & grant_req;
   assign div_op1      = op1_arr[grant_id];
   assign div_op2      = op2_arr[grant_id];
   assign issue_fire   = div_valid_in & div_ready_in;

   always_comb begin
      req_ready = '0;
      if (div_valid_in) req_ready[grant_id] = div_ready_in;
   end

   assign fifo_nonempty = (cnt_q != '0);
   assign head_id       = tag_q[rd_ptr_q];

   always_comb begin
      resp_valid = '0;
      if (fifo_nonempty) resp_valid[head_id] = div_valid_out;
   end

   assign resp_result   = div_result;
   assign div_ready_out = fifo_nonempty & resp_ready[head_id];
   assign pop_fire      = div_valid_out & div_ready_out;

   always_comb begin
      cnt_d = cnt_q;
      case ({issue_fire, pop_fire})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (issue_fire) rr_ptr_d = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
   end

   assign lock_d    = div_valid_in & ~div_ready_in;
   assign lock_id_d = grant_id;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_RUN;
         rr_ptr_q     <= '0;
         lock_q       <= 1'b0;
         lock_id_q    <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         err_orphan_q <= 1'b0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
         cnt_q     <= cnt_d;
         if (issue_fire) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_fire)   rd_ptr_q <= rd_ptr_q + PW'(1);
         if (div_valid_out && !fifo_nonempty) err_orphan_q <= 1'b1;
         case (state_q)
            ST_RUN:   if (flush) state_q <= ST_DRAIN;
            ST_DRAIN: if (cnt_d == '0) state_q <= ST_DONE;
            ST_DONE:  if (!flush) state_q <= ST_RUN;
            default:  state_q <= ST_RUN;
         endcase
      end
   end

   // Tag storage needs no reset: entries are only read while counted as valid.
   always_ff @(posedge clk) begin
      if (issue_fire) tag_q[wr_ptr_q] <= grant_id;
   end

   assign flush_done = (state_q == ST_DONE);
   assign busy       = fifo_nonempty;
   assign err_orphan = err_orphan_q;

endmodule
